// File: rtl/mdr_pkg.sv
// Shared types, lane positions and default parameter values for the
// parametrised memory data register (mdr_gen).
package mdr_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_BUS_W       = 16;
    localparam int DEF_TIMEOUT_CYC = 15;
    localparam int DEF_CNT_W       = 4;

    localparam int LO_LANE_LSB = 0;
    localparam int UP_LANE_LSB = DEF_BUS_W - DEF_DATA_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } mdrState_e;

    // Upper lane position for a non-default bus/word combination.
    function automatic int upLaneLsb(input int busW, input int dataW);
        return busW - dataW;
    endfunction

endpackage

// File: rtl/mdr_tri_lane.sv
// One byte lane of W-bus drive: a row of bufif1 gates sharing one enable.
module mdr_tri_lane #(
    parameter int W = 8
) (
    input  logic         iEn,
    input  logic [W-1:0] iD,
    output tri   [W-1:0] oY
);

    for (genvar i = 0; i < W; i++) begin : gBuf
        bufif1 uBuf (oY[i], iD[i], iEn);
    end

endmodule

// File: rtl/mdr_gen.sv
// Memory data register with req/ack memory handshake, timeout watchdog and
// dual-lane tristate W-bus drive. Optional read parity check: MDR_PARITY_EN.
module mdr_gen
    import mdr_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BUS_W       = DEF_BUS_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iLmdr,
    input  logic              iRm,
    input  logic [BUS_W-1:0]  iwBus,
    input  logic [DATA_W-1:0] iMem,
    input  logic              iMemAck,
    input  logic              iEnBus,
    input  logic              iEnableUN,
    output logic [DATA_W-1:0] oQ,
    output logic [DATA_W-1:0] oMem,
    output logic              oMemReq,
    output logic              oMemWe,
    output logic              oBusy,
    output logic              oTimeout,
`ifdef MDR_PARITY_EN
    input  logic              iMemPar,
    output logic              oParErr,
`endif
    output tri   [BUS_W-1:0]  owBus
);

    localparam int UpLsb = upLaneLsb(BUS_W, DATA_W);

    mdrState_e         state_r;
    mdrState_e         nextState_s;
    logic [CNT_W-1:0]  wdog_r;
    logic [CNT_W-1:0]  wdogNext_s;
    logic [DATA_W-1:0] qNext_s;
    logic [DATA_W-1:0] memNext_s;
    logic              reqNext_s;
    logic              weNext_s;
    logic              toNext_s;
    logic              expire_s;
    logic              enLo_s;
    logic              enUp_s;
    logic              unusedBits_s;

    assign unusedBits_s = ^iwBus[BUS_W-1:DATA_W];
    assign expire_s     = (wdog_r == CNT_W'(TIMEOUT_CYC - 1));

`ifdef MDR_PARITY_EN
    logic parErrNext_s;

    // Even parity: a set result means data and parity bit disagree.
    function automatic logic parityErr(input logic [DATA_W-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction
`endif

    // Next-state decode; an ack beats the watchdog on the expiry cycle.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (iLmdr) begin
                    nextState_s = iRm ? WR_WAIT : RD_WAIT;
                end else begin
                    nextState_s = IDLE;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (iMemAck || expire_s) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = state_r;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and the watchdog.
    always_comb begin
        qNext_s    = oQ;
        memNext_s  = oMem;
        reqNext_s  = oMemReq;
        weNext_s   = oMemWe;
        toNext_s   = oTimeout;
        wdogNext_s = wdog_r;
`ifdef MDR_PARITY_EN
        parErrNext_s = oParErr;
`endif
        case (state_r)
            IDLE: begin
                if (iLmdr) begin
                    reqNext_s  = 1'b1;
                    weNext_s   = iRm;
                    toNext_s   = 1'b0;
                    wdogNext_s = {CNT_W{1'b0}};
`ifdef MDR_PARITY_EN
                    parErrNext_s = 1'b0;
`endif
                    if (iRm) begin
                        qNext_s   = iwBus[DATA_W-1:0];
                        memNext_s = iwBus[DATA_W-1:0];
                    end else begin
                        memNext_s = {DATA_W{1'b0}};
                    end
                end else begin
                    reqNext_s = 1'b0;
                    weNext_s  = 1'b0;
                    memNext_s = {DATA_W{1'b0}};
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (iMemAck) begin
                    reqNext_s = 1'b0;
                    weNext_s  = 1'b0;
                    memNext_s = {DATA_W{1'b0}};
                    if (state_r == RD_WAIT) begin
                        qNext_s = iMem;
`ifdef MDR_PARITY_EN
                        parErrNext_s = parityErr(iMem, iMemPar);
`endif
                    end else begin
                        qNext_s = oQ;
                    end
                end else if (expire_s) begin
                    reqNext_s = 1'b0;
                    weNext_s  = 1'b0;
                    memNext_s = {DATA_W{1'b0}};
                    toNext_s  = 1'b1;
                end else begin
                    wdogNext_s = wdog_r + CNT_W'(1);
                end
            end
            default: begin
                reqNext_s = 1'b0;
                weNext_s  = 1'b0;
                memNext_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // State, watchdog and registered outputs.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r  <= IDLE;
            wdog_r   <= {CNT_W{1'b0}};
            oQ       <= {DATA_W{1'b0}};
            oMem     <= {DATA_W{1'b0}};
            oMemReq  <= 1'b0;
            oMemWe   <= 1'b0;
            oBusy    <= 1'b0;
            oTimeout <= 1'b0;
`ifdef MDR_PARITY_EN
            oParErr  <= 1'b0;
`endif
        end else begin
            state_r  <= nextState_s;
            wdog_r   <= wdogNext_s;
            oQ       <= qNext_s;
            oMem     <= memNext_s;
            oMemReq  <= reqNext_s;
            oMemWe   <= weNext_s;
            oBusy    <= (nextState_s != IDLE);
            oTimeout <= toNext_s;
`ifdef MDR_PARITY_EN
            oParErr  <= parErrNext_s;
`endif
        end
    end

    // The register only talks to the bus when idle and not in write direction.
    assign enLo_s = iEnBus    & ~iRm & ~oBusy;
    assign enUp_s = iEnableUN & ~iRm & ~oBusy;

    mdr_tri_lane #(.W(DATA_W)) uLoLane (
        .iEn (enLo_s),
        .iD  (oQ),
        .oY  (owBus[LO_LANE_LSB +: DATA_W])
    );

    mdr_tri_lane #(.W(DATA_W)) uUpLane (
        .iEn (enUp_s),
        .iD  (oQ),
        .oY  (owBus[UpLsb +: DATA_W])
    );

endmodule

// File: tb/tb_mdr_gen.sv
// Self-checking bench for mdr_gen: directed vector table, hand-written
// multi-cycle corner cases and randomized traffic against a reference model.
module tb_mdr_gen;

    logic        clk;
    logic        rst;
    logic        lmdr;
    logic        rm;
    logic [15:0] wbusIn;
    logic [7:0]  memIn;
    logic        ack;
    logic        enBus;
    logic        enUn;
    logic [7:0]  q;
    logic [7:0]  memOut;
    logic        memReq;
    logic        memWe;
    logic        busy;
    logic        timeout;
    tri   [15:0] wBus;
`ifdef MDR_PARITY_EN
    logic        memPar;
    logic        parErr;
    logic        mPe;
`endif

    int nCmp  = 0;
    int nFail = 0;

    // Undriven lanes read as all ones, so a floating lane is visible as 8'hFF.
    for (genvar g = 0; g < 16; g++) begin : gPull
        pullup pu (wBus[g]);
    end

    mdr_gen dut (
        .iClk      (clk),
        .iRst      (rst),
        .iLmdr     (lmdr),
        .iRm       (rm),
        .iwBus     (wbusIn),
        .iMem      (memIn),
        .iMemAck   (ack),
        .iEnBus    (enBus),
        .iEnableUN (enUn),
        .oQ        (q),
        .oMem      (memOut),
        .oMemReq   (memReq),
        .oMemWe    (memWe),
        .oBusy     (busy),
        .oTimeout  (timeout),
`ifdef MDR_PARITY_EN
        .iMemPar   (memPar),
        .oParErr   (parErr),
`endif
        .owBus     (wBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a transfer is open until acked or until its 15th
    // consecutive cycle without an ack.
    localparam int TIMEOUT = 15;
    bit       mBusy;
    bit       mWrite;
    int       mWaited;
    bit [7:0] mQ;
    bit [7:0] mMem;
    bit       mReq;
    bit       mWe;
    bit       mTo;

    task automatic modelClose();
        mBusy = 1'b0;
        mReq  = 1'b0;
        mWe   = 1'b0;
        mMem  = 8'h00;
    endtask

    task automatic modelStep();
        if (rst) begin
            modelClose();
            mQ  = 8'h00;
            mTo = 1'b0;
`ifdef MDR_PARITY_EN
            mPe = 1'b0;
`endif
        end else if (!mBusy) begin
            if (lmdr) begin
                mBusy   = 1'b1;
                mWrite  = rm;
                mWaited = 0;
                mTo     = 1'b0;
                mReq    = 1'b1;
                mWe     = rm;
`ifdef MDR_PARITY_EN
                mPe     = 1'b0;
`endif
                if (rm) begin
                    mQ   = wbusIn[7:0];
                    mMem = wbusIn[7:0];
                end
            end
        end else if (ack) begin
            if (!mWrite) begin
                mQ = memIn;
`ifdef MDR_PARITY_EN
                mPe = ($countones({memIn, memPar}) % 2) != 0;
`endif
            end
            modelClose();
        end else begin
            mWaited++;
            if (mWaited == TIMEOUT) begin
                mTo = 1'b1;
                modelClose();
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] modelBus();
        logic [7:0] lo;
        logic [7:0] hi;
        lo = (enBus & ~rm & ~mBusy) ? mQ : 8'hFF;
        hi = (enUn  & ~rm & ~mBusy) ? mQ : 8'hFF;
        return {hi, lo};
    endfunction

    task automatic tick(input logic r, input logic l, input logic d, input logic [15:0] wb,
                        input logic [7:0] m, input logic a, input logic e, input logic eu);
        rst = r; lmdr = l; rm = d; wbusIn = wb; memIn = m; ack = a; enBus = e; enUn = eu;
        @(posedge clk);
        modelStep();
        #1;
        chk("model_q",       32'(q),       32'(mQ));
        chk("model_mem",     32'(memOut),  32'(mMem));
        chk("model_req",     32'(memReq),  32'(mReq));
        chk("model_we",      32'(memWe),   32'(mWe));
        chk("model_busy",    32'(busy),    32'(mBusy));
        chk("model_timeout", 32'(timeout), 32'(mTo));
        chk("model_bus",     32'(wBus),    32'(modelBus()));
`ifdef MDR_PARITY_EN
        chk("model_parerr",  32'(parErr),  32'(mPe));
`endif
    endtask

    typedef struct {
        logic        lmdr;
        logic        rm;
        logic [15:0] wb;
        logic [7:0]  mem;
        logic        ack;
        logic        en;
        logic        enU;
        logic [7:0]  eQ;
        logic        eReq;
        logic        eWe;
        logic [7:0]  eMem;
        logic        eBusy;
        logic        eTo;
        logic [15:0] eBus;
    } vec_t;

    vec_t vecs[$];

    initial begin
`ifdef MDR_PARITY_EN
        memPar = 1'b0;
`endif
        // read A5 acked on the third wait cycle
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'hFFFF});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'hFFFF});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'hFFFF});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA5A5});
        // write 3C from the low lane of the bus
        vecs.push_back('{1'b1, 1'b1, 16'h123C, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 16'hFFFF});
        vecs.push_back('{1'b0, 1'b1, 16'h123C, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 16'hFFFF});
        vecs.push_back('{1'b0, 1'b1, 16'h123C, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hFFFF});
        // load 5A, then lane-drive patterns; ack while idle is ignored
        vecs.push_back('{1'b1, 1'b1, 16'h005A, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 16'hFFFF});
        vecs.push_back('{1'b0, 1'b1, 16'h005A, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hFFFF});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 8'h99, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hFF5A});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h5AFF});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h5A5A});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hFFFF});
        // busy read floats the bus; a second strobe mid-read is ignored
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'hFFFF});
        vecs.push_back('{1'b1, 1'b1, 16'h0077, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'hFFFF});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hC3C3});

        // reset state
        tick(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 16'hFFFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("rst_q",    32'(q),       32'h0);
        chk("rst_req",  32'(memReq),  32'h0);
        chk("rst_we",   32'(memWe),   32'h0);
        chk("rst_mem",  32'(memOut),  32'h0);
        chk("rst_busy", 32'(busy),    32'h0);
        chk("rst_to",   32'(timeout), 32'h0);
        chk("rst_bus",  32'(wBus),    32'hFFFF);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(1'b0, vecs[i].lmdr, vecs[i].rm, vecs[i].wb, vecs[i].mem, vecs[i].ack,
                 vecs[i].en, vecs[i].enU);
            chk($sformatf("vec%0d_q", i),    32'(q),       32'(vecs[i].eQ));
            chk($sformatf("vec%0d_req", i),  32'(memReq),  32'(vecs[i].eReq));
            chk($sformatf("vec%0d_we", i),   32'(memWe),   32'(vecs[i].eWe));
            chk($sformatf("vec%0d_mem", i),  32'(memOut),  32'(vecs[i].eMem));
            chk($sformatf("vec%0d_busy", i), 32'(busy),    32'(vecs[i].eBusy));
            chk($sformatf("vec%0d_to", i),   32'(timeout), 32'(vecs[i].eTo));
            chk($sformatf("vec%0d_bus", i),  32'(wBus),    32'(vecs[i].eBus));
        end

        // read with no ack: still busy after 14 waits, abandoned on the 15th
        tick(1'b0, 1'b1, 1'b0, 16'h0000, 8'h11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h11, 1'b0, 1'b0, 1'b0);
        chk("to_busy_before", 32'(busy), 32'h1);
        chk("to_flag_before", 32'(timeout), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h11, 1'b0, 1'b0, 1'b0);
        chk("to_busy_after", 32'(busy),    32'h0);
        chk("to_flag_after", 32'(timeout), 32'h1);
        chk("to_q_kept",     32'(q),       32'hC3);
        chk("to_req_drop",   32'(memReq),  32'h0);

        // next strobe clears the flag; ack on the expiry cycle wins
        tick(1'b0, 1'b1, 1'b0, 16'h0000, 8'h66, 1'b0, 1'b0, 1'b0);
        chk("to_clear", 32'(timeout), 32'h0);
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h66, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h66, 1'b1, 1'b0, 1'b0);
        chk("expiry_ack_to",   32'(timeout), 32'h0);
        chk("expiry_ack_q",    32'(q),       32'h66);
        chk("expiry_ack_busy", 32'(busy),    32'h0);

        // reset in the middle of a write, then a stale ack
        tick(1'b0, 1'b1, 1'b1, 16'h00E7, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("wr_q", 32'(q), 32'hE7);
        tick(1'b0, 1'b0, 1'b1, 16'h00E7, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 16'h00E7, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("wr_rst_req",  32'(memReq), 32'h0);
        chk("wr_rst_we",   32'(memWe),  32'h0);
        chk("wr_rst_busy", 32'(busy),   32'h0);
        tick(1'b0, 1'b0, 1'b1, 16'h00E7, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("stale_ack_req",  32'(memReq), 32'h0);
        chk("stale_ack_busy", 32'(busy),   32'h0);
        chk("stale_ack_q",    32'(q),      32'h00);

`ifdef MDR_PARITY_EN
        memPar = 1'b0;
        tick(1'b0, 1'b1, 1'b0, 16'h0000, 8'h01, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h01, 1'b1, 1'b0, 1'b0);
        chk("par_err_set", 32'(parErr), 32'h1);
        chk("par_err_q",   32'(q),      32'h01);
        tick(1'b0, 1'b1, 1'b0, 16'h0000, 8'h03, 1'b0, 1'b0, 1'b0);
        chk("par_err_clr_strobe", 32'(parErr), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 8'h03, 1'b1, 1'b0, 1'b0);
        chk("par_ok", 32'(parErr), 32'h0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
`ifdef MDR_PARITY_EN
            memPar = 1'($urandom_range(0, 1));
`endif
            tick(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/mdr_gen.md
Name: mdr_gen

Overview:
- Parametrised memory data register for the SAP-2 datapath; successor to the fixed 8-bit MDR.
- Moves one DATA_W word between the W-bus and memory through a request/acknowledge handshake, so memory may insert wait states.
- Adds a timeout watchdog and a busy indication.
- Drives the stored word onto the low and/or upper byte lane of the wide W-bus through tristate buffers.

Parameters:
- DATA_W, 8, width of the memory word and of the register.
- BUS_W, 16, W-bus width; must satisfy BUS_W >= 2*DATA_W.
- TIMEOUT_CYC, 15, wait-state cycles allowed before a transfer is abandoned; must be >= 1.
- CNT_W, 4, watchdog counter width; must hold TIMEOUT_CYC.

Ports:
- iClk  in  1  sole clock, rising edge.
- iRst  in  1  synchronous, active-high reset.
- iLmdr  in  1  start a transfer (one-cycle strobe, sampled only in IDLE).
- iRm  in  1  direction, sampled with iLmdr: 0 = read memory into MDR, 1 = write bus word to memory.
- iwBus  in  BUS_W  W-bus input; bits [DATA_W-1:0] are loaded on a write.
- iMem  in  DATA_W  read data from memory.
- iMemAck  in  1  memory acknowledge; completes the pending request.
- iEnBus  in  1  drive oQ onto the low lane of owBus.
- iEnableUN  in  1  drive oQ onto the upper lane of owBus.
- oQ  out  DATA_W  register contents.
- oMem  out  DATA_W  write data to memory.
- oMemReq  out  1  memory request.
- oMemWe  out  1  write enable, qualifies oMemReq.
- oBusy  out  1  transfer in progress.
- oTimeout  out  1  sticky flag: the last transfer timed out.
- owBus  out (tri)  BUS_W  W-bus drive.

Behaviour:
- Clock and reset: one clock, iClk. Reset iRst is synchronous and active-high.
- Reset values: state=IDLE, oQ=0, oMemReq=0, oMemWe=0, oMem=0, oBusy=0, oTimeout=0, watchdog=0, owBus all Z.
- FSM states: IDLE, RD_WAIT, WR_WAIT. All outputs except owBus are registered.
- IDLE, iLmdr=1, iRm=0:
  - next state RD_WAIT; oMemReq=1, oMemWe=0; oTimeout cleared; watchdog cleared.
- IDLE, iLmdr=1, iRm=1:
  - oQ <= iwBus[DATA_W-1:0] on the same edge; next state WR_WAIT.
  - oMemReq=1, oMemWe=1, oMem=that word; oTimeout cleared.
- RD_WAIT:
  - iMemAck=1: oQ <= iMem; go to IDLE; oMemReq drops.
  - No ack: watchdog increments.
- WR_WAIT:
  - iMemAck=1: go to IDLE; oMemReq, oMemWe and oMem return to 0.
  - No ack: watchdog increments.
- Timeout: if the watchdog equals TIMEOUT_CYC-1 and iMemAck=0, go to IDLE and set oTimeout=1. oQ is unchanged on a read timeout.
- Ack on the expiry cycle: ack wins, transfer completes, oTimeout stays 0.
- oBusy = (state != IDLE).
- Ignored inputs: iLmdr while busy (no queueing); iMemAck in IDLE.
- Latency:
  - read: iLmdr edge N, earliest ack sampled at edge N+1, oQ valid after N+1.
  - write: oQ valid after edge N.
- Bus drive (combinational, no registers):
  - owBus[DATA_W-1:0] = oQ when iEnBus & ~iRm & ~oBusy.
  - owBus[BUS_W-1:BUS_W-DATA_W] = oQ when iEnableUN & ~iRm & ~oBusy.
  - Both lanes may be driven together. All other bits and any disabled lane are Z.
- Reset mid-transfer: the next edge forces IDLE; oMemReq and oMemWe are 0 after that edge; the pending ack is ignored.

Optional Feature:
- Macro: MDR_PARITY_EN.
- When defined:
  - Adds port iMemPar (in, 1), the even-parity bit of the read data.
  - Adds port oParErr (out, 1, sticky).
  - On a read ack, oParErr <= ^iMem ^ iMemPar. It is cleared by iRst or by the next accepted iLmdr.
  - oQ is still loaded on a parity error.
- When undefined: neither port exists and there is no parity logic.

Decomposition:
- Package mdr_pkg holds:
  - the state enum: IDLE, RD_WAIT, WR_WAIT;
  - lane index constants: LO_LANE_LSB=0, UP_LANE_LSB=BUS_W-DATA_W;
  - the default parameter values.
- One sub-module, mdr_tri_lane: a DATA_W-bit bufif1 row with an enable. It is instantiated twice, once for the low lane and once for the upper lane.

Test Plan:
- Reset, then read: iLmdr=1 with iRm=0, iMem=8'hA5, ack 3 cycles later -> oMemReq high 3 cycles, oQ=8'hA5, oBusy low the cycle after ack, oTimeout=0.
- Write: iwBus=16'h123C, iLmdr=1 with iRm=1 -> oQ=8'h3C next cycle, oMem=8'h3C with oMemWe=1 until ack, then oMem=0.
- Lane drive: oQ=8'h5A, iRm=0, idle; iEnBus=1 only -> owBus=16'hZZ5A; iEnableUN=1 only -> 16'h5AZZ; both -> 16'h5A5A; while busy -> all Z.
- Timeout: read with no ack, TIMEOUT_CYC=15 -> IDLE after 15 wait cycles, oTimeout=1, oQ unchanged; next iLmdr clears oTimeout.
- Corner cases:
  - ack exactly on the expiry cycle -> completes, oTimeout=0;
  - iLmdr pulsed during RD_WAIT -> ignored;
  - iRst asserted in WR_WAIT -> IDLE next edge, oMemReq=0, a later ack is ignored.
- With MDR_PARITY_EN: read iMem=8'h01 with iMemPar=0 -> oParErr=1; the next read with correct parity after iLmdr -> oParErr=0.
